tqvp_vga_scan_timing: RTL and testbench
=======================================

Name: tqvp_vga_scan_timing

Overview:
- Raster timing generator that sits directly upstream of the VGA pixel/VRAM stage in the TinyQV VGA peripheral.
- Produces the beam position (x, y), sync pulses, blank, a per-line retrace strobe and a sticky vblank interrupt.
- Default timing is 1024x768@60 driven from the 64 MHz project clock, one pixel per clock.
- The downstream stage uses blank/retrace to walk VRAM; the CPU clears the interrupt through cli.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FRONT, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync width (clocks)
- H_BACK, 160, horizontal back porch (clocks)
- V_ACTIVE, 768, visible lines per frame
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BACK, 29, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync

Ports:
- clk  in  1  project clock (64 MHz)
- rst_n  in  1  asynchronous active-low reset
- cli  in  1  clear interrupt (level; any cycle high clears)
- x  out  11  horizontal position, 0..H_TOTAL-1
- y  out  10  vertical line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- retrace  out  1  one-cycle new-scanline strobe
- blank  out  1  high outside the active area
- interrupt  out  1  sticky vblank interrupt

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All state is on posedge clk with async clear on negedge rst_n.
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 1344).
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (default 806).
- Reset values: x=0, y=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, blank=0, retrace=0, interrupt=0. All take effect immediately on rst_n low, without a clock.
- x counter: increments every clock. At x==H_TOTAL-1 it wraps to 0 and y advances.
- y counter: wraps from V_TOTAL-1 to 0 on the same clock that x wraps.
- Output alignment: every output is a flop. hsync, vsync, blank and retrace are decoded from the next (x, y), so in any cycle they describe the (x, y) shown in that same cycle. Zero skew, no combinational paths to outputs.
- blank = (x >= H_ACTIVE) || (y >= V_ACTIVE).
- hsync is at level HSYNC_POL when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (default 1048..1183). Otherwise it is at !HSYNC_POL.
- vsync is at level VSYNC_POL when V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (default 771..776). Otherwise it is at !VSYNC_POL.
- retrace: high for exactly one cycle, at x==H_ACTIVE, on lines with y < V_ACTIVE. It never fires during vblank lines, giving exactly V_ACTIVE strobes per frame.
- Interrupt set event: the cycle in which (x, y) == (0, V_ACTIVE).
- Interrupt hold and clear: interrupt stays high until a cycle with cli=1 clears it.
- Simultaneous set and cli: set wins, interrupt stays 1, so no event is lost.
- cli while interrupt=0 has no effect.
- Arithmetic is unsigned. Widths are fixed at 11/10 bits; parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024. Elaboration fails otherwise (generate-time check).
- Reset mid-frame: counters restart at (0,0) and any pending interrupt is dropped. The first frame after reset is complete and full length.

Optional Feature:
- Macro: VGA_SCAN_TIMING_HBLANK_IRQ_EN.
- Defined: interrupt is additionally set on every retrace strobe (each visible line's hblank start). The same sticky/cli rules apply, and set still wins over cli.
- Undefined: interrupt is set only by the vblank event. No extra logic is generated.

Decomposition:
- Package vga_scan_timing_pkg holds:
  - default timing constants (1024x768@60 values above);
  - derived H_TOTAL/V_TOTAL;
  - sync/blank start/end localparams;
  - X_W=11, Y_W=10.
- One natural sub-module: vga_scan_counter, a parameterised wrap counter with a terminal-count output.
  - Instance 1: horizontal, always enabled.
  - Instance 2: vertical, enabled by the horizontal terminal count.
- The top module holds the registered decodes and the interrupt flop.

Test Plan:
1. Release reset → x counts 0..1343, then wraps to 0 with y 0→1 on the same cycle. The frame repeats every 1,083,264 clocks (y wraps 805→0).
2. Line scan → blank rises at x=1024 and falls at x=0 of the next visible line. hsync is low exactly for x=1048..1183 (136 clocks), aligned to x with no skew.
3. Frame scan → vsync is low for y=771..776. blank is high for the whole of lines 768..805. retrace pulses once per line at x=1024 for y=0..767 (768 pulses per frame) and never for y≥768.
4. Interrupt → rises in the cycle where (x, y) == (0, 768) and holds. cli=1 at (5,770) clears it the next cycle. cli=1 exactly at (0,768) leaves interrupt=1.
5. Async reset asserted at x=500, y=300 between clock edges → all outputs go to reset values immediately. After release, counting restarts from (0,0) and no stale interrupt remains.
6. With VGA_SCAN_TIMING_HBLANK_IRQ_EN → interrupt sets at (1024,0). cli at (1100,0) clears it, and it sets again at (1024,1). Without the macro, no interrupt occurs before y=768.

Source files
------------

// File: rtl/vga_scan_timing_pkg.sv
// vga_scan_timing_pkg: default 1024x768@60 raster constants, counter widths and window helper
package vga_scan_timing_pkg;
    localparam int X_W = 11;
    localparam int Y_W = 10;
    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FRONT = 24;
    localparam int DEF_H_SYNC = 136;
    localparam int DEF_H_BACK = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FRONT = 3;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BACK = 29;
    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int DEF_HS_END = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FRONT;
    localparam int DEF_VS_END = DEF_VS_START + DEF_V_SYNC;

    function automatic bit in_window(int v, int lo, int hi);
        return v >= lo && v < hi;
    endfunction
endpackage

// File: rtl/tqvp_vga_scan_timing_if.sv
// tqvp_vga_scan_timing_if: beam position, sync/blank strobes and interrupt handshake
interface tqvp_vga_scan_timing_if;
    import vga_scan_timing_pkg::*;
    logic cli;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic hsync;
    logic vsync;
    logic retrace;
    logic blank;
    logic interrupt;
    modport master (input cli, output x, y, hsync, vsync, retrace, blank, interrupt);
    modport slave (output cli, input x, y, hsync, vsync, retrace, blank, interrupt);
endinterface

// File: rtl/vga_scan_counter.sv
// vga_scan_counter: wrap counter exposing its next value and terminal count
module vga_scan_counter #(
    parameter int W = 11,
    parameter int LAST = 1343
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt,
    output logic         tc
);
    assign tc = q == W'(LAST);
    assign nxt = en ? (tc ? '0 : q + 1'b1) : q;

    // advance to the precomputed next value
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else q <= nxt;
endmodule

// File: rtl/tqvp_vga_scan_timing.sv
// tqvp_vga_scan_timing: VGA raster timing; define VGA_SCAN_TIMING_HBLANK_IRQ_EN to also raise the interrupt on every retrace
module tqvp_vga_scan_timing
    import vga_scan_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BACK = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BACK = DEF_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input logic clk,
    input logic rst_n,
    tqvp_vga_scan_timing_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END = VS_START + V_SYNC;

    if (H_TOTAL > 2 ** X_W || V_TOTAL > 2 ** Y_W) begin : g_bad_timing
        $error("tqvp_vga_scan_timing: H_TOTAL/V_TOTAL exceed counter widths");
    end

    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic h_tc, v_tc_unused;
    logic blank_n, hsync_n, vsync_n, retrace_n, vb_n, vb_c, set_n, set_c;

    vga_scan_counter #(.W(X_W), .LAST(H_TOTAL - 1)) u_h (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .q(bus.x), .nxt(nx), .tc(h_tc)
    );
    vga_scan_counter #(.W(Y_W), .LAST(V_TOTAL - 1)) u_v (
        .clk(clk), .rst_n(rst_n), .en(h_tc), .q(bus.y), .nxt(ny), .tc(v_tc_unused)
    );

    // decode the upcoming position so registered outputs line up with x/y
    always_comb begin
        blank_n = int'(nx) >= H_ACTIVE || int'(ny) >= V_ACTIVE;
        hsync_n = in_window(int'(nx), HS_START, HS_END) ? HSYNC_POL : !HSYNC_POL;
        vsync_n = in_window(int'(ny), VS_START, VS_END) ? VSYNC_POL : !VSYNC_POL;
        retrace_n = int'(nx) == H_ACTIVE && int'(ny) < V_ACTIVE;
        vb_n = nx == '0 && int'(ny) == V_ACTIVE;
        vb_c = bus.x == '0 && int'(bus.y) == V_ACTIVE;
    end

`ifdef VGA_SCAN_TIMING_HBLANK_IRQ_EN
    assign set_n = vb_n || retrace_n;
    assign set_c = vb_c || bus.retrace;
`else
    assign set_n = vb_n;
    assign set_c = vb_c;
`endif

    // register decodes; a set in the current cycle also shields against cli
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.hsync <= !HSYNC_POL;
            bus.vsync <= !VSYNC_POL;
            bus.blank <= 1'b0;
            bus.retrace <= 1'b0;
            bus.interrupt <= 1'b0;
        end else begin
            bus.hsync <= hsync_n;
            bus.vsync <= vsync_n;
            bus.blank <= blank_n;
            bus.retrace <= retrace_n;
            bus.interrupt <= set_n || set_c || (bus.interrupt && !bus.cli);
        end
endmodule

// File: tb/tb_tqvp_vga_scan_timing.sv
// tb_tqvp_vga_scan_timing: directed checks on default timing and on a shrunken raster
module tb_tqvp_vga_scan_timing;
`ifdef VGA_SCAN_TIMING_HBLANK_IRQ_EN
    localparam bit IRQ_HB = 1'b1;
`else
    localparam bit IRQ_HB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int k, n_run, n_fail;

    always #5 clk = ~clk;

    tqvp_vga_scan_timing_if bd();
    tqvp_vga_scan_timing_if bs();

    tqvp_vga_scan_timing u_dut_d (.clk(clk), .rst_n(rst_n), .bus(bd));

    tqvp_vga_scan_timing #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
        .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

    task automatic check(string tag, int got, int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic adv(int n);
        repeat (n) @(negedge clk);
        k += n;
    endtask

    task automatic goto(int t);
        adv(t - k);
    endtask

    task automatic check_reset(string ph);
        check({ph, "_d_x"}, bd.x, 0);
        check({ph, "_d_y"}, bd.y, 0);
        check({ph, "_d_hsync"}, bd.hsync, 1);
        check({ph, "_d_vsync"}, bd.vsync, 1);
        check({ph, "_d_blank"}, bd.blank, 0);
        check({ph, "_d_retrace"}, bd.retrace, 0);
        check({ph, "_d_irq"}, bd.interrupt, 0);
        check({ph, "_s_x"}, bs.x, 0);
        check({ph, "_s_y"}, bs.y, 0);
        check({ph, "_s_hsync"}, bs.hsync, 0);
        check({ph, "_s_vsync"}, bs.vsync, 0);
        check({ph, "_s_irq"}, bs.interrupt, 0);
    endtask

    initial begin
        int pos_err, s_vs, s_vs_first, s_hs, s_rt, s_rt_bad, s_bl, s_irq_first;
        int d_hs, d_hs_first, d_rt, d_bl, d_irq_rt;
        n_run = 0;
        n_fail = 0;
        k = 0;
        bd.cli = 1'b0;
        bs.cli = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        k = 0;
        pos_err = 0; s_vs = 0; s_vs_first = -1; s_hs = 0;
        s_rt = 0; s_rt_bad = 0; s_bl = 0; s_irq_first = -1;
        for (int i = 0; i < 350; i++) begin
            if (int'(bs.x) != i % 25 || int'(bs.y) != i / 25) pos_err++;
            if (bs.vsync) begin
                s_vs++;
                if (s_vs_first < 0) s_vs_first = i;
            end
            if (bs.hsync) s_hs++;
            if (bs.retrace) begin
                s_rt++;
                if (bs.x != 16 || bs.y >= 8) s_rt_bad++;
            end
            if (bs.blank) s_bl++;
            if (bs.interrupt && s_irq_first < 0) s_irq_first = i;
            adv(1);
        end
        check("s_pos_err", pos_err, 0);
        check("s_vsync_cycles", s_vs, 50);
        check("s_vsync_first", s_vs_first, 225);
        check("s_hsync_cycles", s_hs, 42);
        check("s_retrace_count", s_rt, 8);
        check("s_retrace_bad", s_rt_bad, 0);
        check("s_blank_cycles", s_bl, 222);
        check("s_irq_first", s_irq_first, IRQ_HB ? 16 : 200);
        check("s_wrap_x", bs.x, 0);
        check("s_wrap_y", bs.y, 0);
        check("s_irq_hold", bs.interrupt, 1);
        goto(605);
        check("s_irq_pre_cli", bs.interrupt, 1);
        bs.cli = 1'b1;
        adv(1);
        check("s_irq_cleared", bs.interrupt, 0);
        bs.cli = 1'b0;
        goto(899);
        check("s_irq_before_set", bs.interrupt, IRQ_HB);
        bs.cli = 1'b1;
        adv(1);
        check("s_irq_set_vs_cli", bs.interrupt, 1);
        adv(1);
        check("s_irq_set_wins", bs.interrupt, 1);
        bs.cli = 1'b0;
        goto(1023);
        check("d_x_1023", bd.x, 1023);
        check("d_blank_1023", bd.blank, 0);
        check("d_retrace_1023", bd.retrace, 0);
        goto(1024);
        check("d_x_1024", bd.x, 1024);
        check("d_blank_1024", bd.blank, 1);
        check("d_retrace_1024", bd.retrace, 1);
        check("d_irq_1024", bd.interrupt, IRQ_HB);
        goto(1025);
        check("d_retrace_1025", bd.retrace, 0);
        goto(1047);
        check("d_hsync_1047", bd.hsync, 1);
        goto(1048);
        check("d_hsync_1048", bd.hsync, 0);
        goto(1100);
        bd.cli = 1'b1;
        adv(1);
        check("d_irq_cli", bd.interrupt, 0);
        bd.cli = 1'b0;
        goto(1183);
        check("d_hsync_1183", bd.hsync, 0);
        goto(1184);
        check("d_hsync_1184", bd.hsync, 1);
        goto(1343);
        check("d_x_1343", bd.x, 1343);
        check("d_y_1343", bd.y, 0);
        goto(1344);
        check("d_wrap_x", bd.x, 0);
        check("d_wrap_y", bd.y, 1);
        check("d_blank_line1", bd.blank, 0);
        check("d_vsync_line1", bd.vsync, 1);
        d_hs = 0; d_hs_first = -1; d_rt = 0; d_bl = 0; d_irq_rt = -1;
        for (int i = 0; i < 1344; i++) begin
            if (!bd.hsync) begin
                d_hs++;
                if (d_hs_first < 0) d_hs_first = int'(bd.x);
            end
            if (bd.retrace) d_rt++;
            if (bd.blank) d_bl++;
            if (bd.x == 1024) d_irq_rt = int'(bd.interrupt);
            adv(1);
        end
        check("d_hsync_low", d_hs, 136);
        check("d_hsync_first", d_hs_first, 1048);
        check("d_retrace_line", d_rt, 1);
        check("d_blank_line", d_bl, 320);
        check("d_irq_line1", d_irq_rt, IRQ_HB);
        goto(3188);
        check("d_x_mid", bd.x, 500);
        check("d_y_mid", bd.y, 2);
        check("s_irq_pending", bs.interrupt, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("async");
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        goto(1);
        check("rr_d_x", bd.x, 1);
        check("rr_d_y", bd.y, 0);
        check("rr_d_irq", bd.interrupt, 0);
        check("rr_s_x", bs.x, 1);
        check("rr_s_irq", bs.interrupt, 0);
        goto(199);
        check("rr_s_irq_199", bs.interrupt, IRQ_HB);
        goto(200);
        check("rr_s_irq_200", bs.interrupt, 1);
        check("rr_s_y_200", bs.y, 8);
        goto(350);
        check("rr_s_wrap_x", bs.x, 0);
        check("rr_s_wrap_y", bs.y, 0);
        goto(1344);
        check("rr_d_wrap_x", bd.x, 0);
        check("rr_d_wrap_y", bd.y, 1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
